// File: rtl/y_sig_pkg.sv
// Shared types and defaults for the y-bus signature checker.
package y_sig_pkg;

    localparam int unsigned Y_DW          = 191;
    localparam int unsigned Y_SW          = 32;
    localparam logic [31:0] Y_POLY        = 32'h04C11DB7;
    localparam logic [31:0] Y_SEED        = 32'h00000000;
    localparam int unsigned Y_TIMEOUT_CYC = 64;

    function automatic int unsigned nwords(input int unsigned dw, input int unsigned sw);
        return (dw + sw - 1) / sw;
    endfunction

    localparam int unsigned Y_NWORDS = nwords(Y_DW, Y_SW);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/y_signature_checker_sig_misr.sv
// Folds the y bus into one signature-wide word and computes the next MISR value.
module sig_misr
    import y_sig_pkg::*;
#(
    parameter int unsigned        DW   = Y_DW,
    parameter int unsigned        SW   = Y_SW,
    parameter logic [SW-1:0]      POLY = SW'(Y_POLY)
) (
    input  logic [SW-1:0] sig,
    input  logic [DW-1:0] y,
    output logic [SW-1:0] sig_next
);

    localparam int unsigned NWORDS = nwords(DW, SW);
    localparam int unsigned PW     = NWORDS * SW;

    logic [PW-1:0] y_pad;
    logic [SW-1:0] fold;

    assign y_pad = PW'(y);

    // XOR-compact the zero-padded bus, one SW-bit word at a time
    always_comb begin
        fold = '0;
        for (int i = 0; i < int'(NWORDS); i++) begin
            fold = fold ^ y_pad[i*SW +: SW];
        end
    end

    assign sig_next = {sig[SW-2:0], 1'b0} ^ (sig[SW-1] ? POLY : '0) ^ fold;

endmodule

// File: rtl/y_signature_checker.sv
// Compacts accepted y vectors into a MISR signature and reports pass/fail/timeout.
module y_signature_checker
    import y_sig_pkg::*;
#(
    parameter int unsigned   DW          = Y_DW,
    parameter int unsigned   SW          = Y_SW,
    parameter logic [SW-1:0] POLY        = SW'(Y_POLY),
    parameter logic [SW-1:0] SEED        = SW'(Y_SEED),
    parameter int unsigned   TIMEOUT_CYC = Y_TIMEOUT_CYC
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [15:0]   num_vec,
    input  logic [SW-1:0] exp_sig,
    input  logic [DW-1:0] y,
    input  logic          y_valid,
    output logic          busy,
    output logic          done,
    output logic          pass,
    output logic          timeout,
    output logic [SW-1:0] sig,
    output logic [15:0]   vec_cnt
);

    localparam int unsigned CW = 16;
    localparam int unsigned IW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [IW-1:0] IDLE_MAX = IW'(TIMEOUT_CYC - 1);

    state_t        state, state_nxt;
    logic [SW-1:0] sig_nxt, sig_step;
    logic [CW-1:0] vec_nxt, num_vec_q, num_nxt;
    logic [IW-1:0] idle_cnt, idle_nxt;
    logic          timeout_nxt;

    sig_misr #(
        .DW   (DW),
        .SW   (SW),
        .POLY (POLY)
    ) u_misr (
        .sig      (sig),
        .y        (y),
        .sig_next (sig_step)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            sig       <= SEED;
            vec_cnt   <= '0;
            idle_cnt  <= '0;
            timeout   <= 1'b0;
            num_vec_q <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_nxt;
            sig       <= sig_nxt;
            vec_cnt   <= vec_nxt;
            idle_cnt  <= idle_nxt;
            timeout   <= timeout_nxt;
            num_vec_q <= num_nxt;
            busy      <= (state_nxt == RUN);
            done      <= (state_nxt == DONE);
        end
    end

    // Next-state and datapath updates; start is only honoured outside RUN
    always_comb begin
        state_nxt   = state;
        sig_nxt     = sig;
        vec_nxt     = vec_cnt;
        idle_nxt    = idle_cnt;
        timeout_nxt = timeout;
        num_nxt     = num_vec_q;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    sig_nxt     = SEED;
                    vec_nxt     = '0;
                    idle_nxt    = '0;
                    timeout_nxt = 1'b0;
                    num_nxt     = num_vec;
                    state_nxt   = (num_vec == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (y_valid) begin
                    sig_nxt  = sig_step;
                    vec_nxt  = (vec_cnt == 16'hFFFF) ? vec_cnt : vec_cnt + 16'd1;
                    idle_nxt = '0;
                    if ((17'(vec_cnt) + 17'd1) == 17'(num_vec_q)) begin
                        state_nxt = DONE;
                    end
                end else if (idle_cnt == IDLE_MAX) begin
                    state_nxt   = DONE;
                    timeout_nxt = 1'b1;
                end else begin
                    idle_nxt = idle_cnt + IW'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign pass = (state == DONE) && !timeout && (sig == exp_sig);

endmodule

// File: tb/tb_y_signature_checker.sv
// Directed self-checking bench for y_signature_checker.
module tb_y_signature_checker;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [15:0]  num_vec;
    logic [31:0]  exp_sig;
    logic [190:0] y;
    logic         y_valid;
    logic         busy, done, pass, timeout;
    logic [31:0]  sig;
    logic [15:0]  vec_cnt;

    int checks = 0;
    int errors = 0;

    y_signature_checker dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .num_vec (num_vec),
        .exp_sig (exp_sig),
        .y       (y),
        .y_valid (y_valid),
        .busy    (busy),
        .done    (done),
        .pass    (pass),
        .timeout (timeout),
        .sig     (sig),
        .vec_cnt (vec_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic begin_run(input logic [15:0] n);
        start   = 1'b1;
        num_vec = n;
        tick();
        start   = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; num_vec = '0; exp_sig = '0; y = '0; y_valid = 1'b0;
        #12;
        checks++;
        if ({busy, done, pass, timeout} !== 4'b0000 || sig !== 32'h0 || vec_cnt !== 16'd0) begin
            errors++;
            $display("FAIL reset: flags=%b sig=%h vec_cnt=%0d, want flags=0000 sig=0 vec_cnt=0",
                     {busy, done, pass, timeout}, sig, vec_cnt);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_all_zero();
        exp_sig = 32'h0;
        begin_run(16'd21);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL zero_busy: busy=%b want 1", busy); end
        y = '0; y_valid = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        checks++;
        if (done !== 1'b0 || vec_cnt !== 16'd20) begin
            errors++; $display("FAIL zero_20: done=%b vec_cnt=%0d want 0/20", done, vec_cnt);
        end
        tick();
        y_valid = 1'b0;
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || sig !== 32'h0 || vec_cnt !== 16'd21 || pass !== 1'b1) begin
            errors++;
            $display("FAIL zero_done: done=%b busy=%b sig=%h vec_cnt=%0d pass=%b want 1/0/0/21/1",
                     done, busy, sig, vec_cnt, pass);
        end
    endtask

    task automatic test_single_bit();
        begin_run(16'd1);
        y = '0; y[0] = 1'b1; y_valid = 1'b1;
        tick();
        y_valid = 1'b0;
        checks++;
        if (done !== 1'b1 || sig !== 32'h00000001) begin
            errors++; $display("FAIL bit0: done=%b sig=%h want 1/00000001", done, sig);
        end
        begin_run(16'd1);
        y = '0; y[190] = 1'b1; y_valid = 1'b1;
        tick();
        y_valid = 1'b0;
        checks++;
        if (done !== 1'b1 || sig !== 32'h40000000 || vec_cnt !== 16'd1) begin
            errors++; $display("FAIL bit190: done=%b sig=%h vec_cnt=%0d want 1/40000000/1", done, sig, vec_cnt);
        end
    endtask

    task automatic test_feedback();
        begin_run(16'd2);
        y = '0; y[31] = 1'b1; y_valid = 1'b1;
        tick();
        checks++;
        if (sig !== 32'h80000000 || busy !== 1'b1) begin
            errors++; $display("FAIL fb_first: sig=%h busy=%b want 80000000/1", sig, busy);
        end
        y = '0;
        tick();
        y_valid = 1'b0;
        checks++;
        if (sig !== 32'h04C11DB7 || done !== 1'b1) begin
            errors++; $display("FAIL fb_second: sig=%h done=%b want 04c11db7/1", sig, done);
        end
        exp_sig = 32'h04C11DB7;
        #1;
        checks++;
        if (pass !== 1'b1) begin errors++; $display("FAIL fb_pass: pass=%b want 1", pass); end
        exp_sig = 32'h0;
        #1;
        checks++;
        if (pass !== 1'b0) begin errors++; $display("FAIL fb_nopass: pass=%b want 0", pass); end
    endtask

    task automatic test_gaps();
        logic [31:0] want;
        begin_run(16'd3);
        for (int v = 0; v < 3; v++) begin
            y = '1; y_valid = 1'b0;
            for (int g = 0; g < 3; g++) tick();
            checks++;
            if (vec_cnt !== 16'(v) || busy !== 1'b1) begin
                errors++; $display("FAIL gap_hold%0d: vec_cnt=%0d busy=%b want %0d/1", v, vec_cnt, busy, v);
            end
            y = '0; y[0] = (v == 0); y_valid = 1'b1;
            tick();
        end
        y_valid = 1'b0;
        want = 32'h00000004;
        checks++;
        if (done !== 1'b1 || sig !== want || vec_cnt !== 16'd3 || timeout !== 1'b0) begin
            errors++;
            $display("FAIL gap_done: done=%b sig=%h vec_cnt=%0d timeout=%b want 1/%h/3/0",
                     done, sig, vec_cnt, timeout, want);
        end
    endtask

    task automatic test_timeout();
        exp_sig = 32'h0;
        begin_run(16'd5);
        y_valid = 1'b0;
        for (int i = 0; i < 62; i++) tick();
        checks++;
        if (done !== 1'b0 || busy !== 1'b1) begin
            errors++; $display("FAIL to_early: done=%b busy=%b want 0/1", done, busy);
        end
        tick(); tick();
        checks++;
        if (done !== 1'b1 || timeout !== 1'b1 || pass !== 1'b0 || vec_cnt !== 16'd0) begin
            errors++;
            $display("FAIL to_done: done=%b timeout=%b pass=%b vec_cnt=%0d want 1/1/0/0",
                     done, timeout, pass, vec_cnt);
        end
    endtask

    task automatic test_edge_cases();
        begin_run(16'd0);
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || sig !== 32'h0 || vec_cnt !== 16'd0 || timeout !== 1'b0) begin
            errors++;
            $display("FAIL nvec0: done=%b busy=%b sig=%h vec_cnt=%0d timeout=%b want 1/0/0/0/0",
                     done, busy, sig, vec_cnt, timeout);
        end
        begin_run(16'd2);
        start = 1'b1; num_vec = 16'd1; y = '0; y[0] = 1'b1; y_valid = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || done !== 1'b0 || vec_cnt !== 16'd1 || sig !== 32'h1) begin
            errors++;
            $display("FAIL start_in_run: busy=%b done=%b vec_cnt=%0d sig=%h want 1/0/1/1",
                     busy, done, vec_cnt, sig);
        end
        y = '0;
        tick();
        y_valid = 1'b0;
        checks++;
        if (done !== 1'b1 || vec_cnt !== 16'd2 || sig !== 32'h2) begin
            errors++; $display("FAIL run_finish: done=%b vec_cnt=%0d sig=%h want 1/2/2", done, vec_cnt, sig);
        end
        begin_run(16'd3);
        checks++;
        if (busy !== 1'b1 || done !== 1'b0 || vec_cnt !== 16'd0 || sig !== 32'h0) begin
            errors++;
            $display("FAIL restart: busy=%b done=%b vec_cnt=%0d sig=%h want 1/0/0/0", busy, done, vec_cnt, sig);
        end
    endtask

    task automatic test_reset_mid_run();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        tick();
        begin_run(16'd10);
        y = '0; y[0] = 1'b1; y_valid = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        checks++;
        if (vec_cnt !== 16'd5 || sig !== 32'h0000001F) begin
            errors++; $display("FAIL pre_reset: vec_cnt=%0d sig=%h want 5/0000001f", vec_cnt, sig);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, pass, timeout} !== 4'b0000 || sig !== 32'h0 || vec_cnt !== 16'd0) begin
            errors++;
            $display("FAIL mid_reset: flags=%b sig=%h vec_cnt=%0d want 0000/0/0", {busy, done, pass, timeout}, sig, vec_cnt);
        end
        tick();
        rst_n = 1'b1;
        y_valid = 1'b0;
        tick();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || vec_cnt !== 16'd0) begin
            errors++; $display("FAIL post_reset: busy=%b done=%b vec_cnt=%0d want 0/0/0", busy, done, vec_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_all_zero();
        test_single_bit();
        test_feedback();
        test_gaps();
        test_timeout();
        test_edge_cases();
        test_reset_mid_run();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

endmodule
